clkdiv_multi: RTL

Multi-channel programmable clock-enable generator; the parametrised successor to the fixed display clock divider. Each of NCH channels has its own runtime-loadable period. Each produces a one-cycle `tick` enable and a 50%-duty `sq` square wave, all in the `clk` domain. Display multiplexing, step-sample timers and debouncers use `tick` as an enable, so no derived clocks are created. Defaults make `sq[0]` toggle every 2^18 cycles, the legacy display refresh rate.

---
 rtl/clkdiv_multi.sv | 71 +++++++
 1 files changed

// File: rtl/clkdiv_multi.sv
// rtl/clkdiv_multi.sv - multi-channel programmable tick / square-wave enable generator
module clkdiv_multi #(
    parameter int WIDTH   = 20,
    parameter int NCH     = 2,
    parameter int DEF_DIV = 262143
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             ld,
    input  logic [3:0]       ld_ch,
    input  logic [WIDTH-1:0] ld_val,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   sq
);

    localparam logic [WIDTH-1:0] DEF = WIDTH'(DEF_DIV);

    genvar i;
    generate
        for (i = 0; i < NCH; i++) begin : g_ch
            logic [WIDTH-1:0] cnt;
            logic [WIDTH-1:0] act;
            logic [WIDTH-1:0] pend;
            logic [WIDTH-1:0] pend_nxt;
            logic             hit;
            logic             tick_r;
            logic             sq_r;

            // A load landing on the same edge as a wrap or sync bypasses pend
            // so the freshly written divisor is used for the very next period.
            assign hit      = ld && (ld_ch == 4'(i));
            assign pend_nxt = hit ? ld_val : pend;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    cnt    <= '0;
                    act    <= DEF;
                    pend   <= DEF;
                    tick_r <= 1'b0;
                    sq_r   <= 1'b0;
                end else begin
                    pend <= pend_nxt;
                    if (sync) begin
                        cnt    <= '0;
                        act    <= pend_nxt;
                        tick_r <= 1'b0;
                        sq_r   <= 1'b0;
                    end else if (en) begin
                        if (cnt == act) begin
                            cnt    <= '0;
                            act    <= pend_nxt;
                            tick_r <= 1'b1;
                            sq_r   <= ~sq_r;
                        end else begin
                            cnt    <= cnt + WIDTH'(1);
                            tick_r <= 1'b0;
                        end
                    end else begin
                        tick_r <= 1'b0;
                    end
                end
            end

            assign tick[i] = tick_r;
            assign sq[i]   = sq_r;
        end
    endgenerate

endmodule
